// File: rtl/dft_mux_switch_ctrl.sv
// dft_mux_switch_ctrl: sequences functional/test mux select changes behind a gated path enable
module dft_mux_switch_ctrl #(
  parameter int QUIET_CYCLES  = 4,
  parameter int SETTLE_CYCLES = 8,
  parameter int CNT_WIDTH     = 4
) (
  input  logic CLK,
  input  logic RST,
  input  logic req_test,
  input  logic lock,
  output logic mux_sel,
  output logic path_en,
  output logic busy,
  output logic switch_done
);
  typedef enum logic [1:0] {STABLE, QUIESCE, FLIP, SETTLE} state_t;
  localparam logic [CNT_WIDTH-1:0] QUIET_LAST  = CNT_WIDTH'(QUIET_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] SETTLE_LAST = CNT_WIDTH'(SETTLE_CYCLES - 1);
  state_t state, state_nxt;
  logic [CNT_WIDTH-1:0] cnt, cnt_nxt;
  logic differ, sel_nxt, en_nxt, busy_nxt, done_nxt;
  assign differ = req_test != mux_sel;
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state       <= STABLE;
      cnt         <= '0;
      mux_sel     <= 1'b0;
      path_en     <= 1'b1;
      busy        <= 1'b0;
      switch_done <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      mux_sel     <= sel_nxt;
      path_en     <= en_nxt;
      busy        <= busy_nxt;
      switch_done <= done_nxt;
    end
  end
  // Abort only while quiescing; once the select has flipped the sequence runs to completion
  always_comb begin
    state_nxt = state == STABLE  ? ((!lock && differ) ? QUIESCE : STABLE) :
                state == QUIESCE ? (!differ ? STABLE : (cnt == QUIET_LAST) ? FLIP : QUIESCE) :
                state == FLIP    ? SETTLE :
                (cnt == SETTLE_LAST) ? STABLE : SETTLE;
    cnt_nxt   = (state_nxt == state && state != STABLE) ? cnt + 1'b1 : '0;
  end
  always_comb begin
    sel_nxt  = (state == FLIP) ? ~mux_sel : mux_sel;
    en_nxt   = state_nxt == STABLE;
    busy_nxt = state_nxt != STABLE;
    done_nxt = state == SETTLE && state_nxt == STABLE;
  end
endmodule

// File: tb/tb_dft_mux_switch_ctrl.sv
// tb_dft_mux_switch_ctrl: directed stimulus checked against a timeline model and literal expectations
module tb_dft_mux_switch_ctrl;
  localparam int Q = 4;
  localparam int S = 8;
  logic clk = 1'b0, rst = 1'b0, req_test = 1'b0, lock = 1'b0;
  logic mux_sel, path_en, busy, switch_done;
  int checks = 0, errors = 0;
  bit m_sel, m_active, m_done, m_valid, m_rst_edge;
  int el;
  logic prev_sel, prev_en;
  bit prev_ok;

  dft_mux_switch_ctrl #(.QUIET_CYCLES(Q), .SETTLE_CYCLES(S), .CNT_WIDTH(4)) dut (
    .CLK(clk), .RST(rst), .req_test(req_test), .lock(lock),
    .mux_sel(mux_sel), .path_en(path_en), .busy(busy), .switch_done(switch_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  // Model: a sequence is an elapsed-edge count from its start edge
  always @(posedge clk) begin
    m_done = 1'b0;
    m_rst_edge = !rst;
    if (!rst) begin
      m_sel = 1'b0;
      m_active = 1'b0;
    end else if (!m_active) begin
      if (!lock && req_test != m_sel) begin
        m_active = 1'b1;
        el = 0;
      end
    end else begin
      el++;
      if (el <= Q && req_test == m_sel) m_active = 1'b0;
      else if (el == Q + 1) m_sel = ~m_sel;
      else if (el == Q + 1 + S) begin
        m_active = 1'b0;
        m_done = 1'b1;
      end
    end
    m_valid = 1'b1;
  end

  always @(posedge clk) begin
    #2;
    if (m_valid) begin
      chk("mux_sel", mux_sel, m_sel);
      chk("path_en", path_en, !m_active);
      chk("busy", busy, m_active);
      chk("switch_done", switch_done, m_done);
      if (prev_ok && !m_rst_edge) chk("sel_toggle_gated", (mux_sel != prev_sel) && prev_en, 1'b0);
      prev_sel = mux_sel;
      prev_en = path_en;
      prev_ok = 1'b1;
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    step(3);
    rst = 1'b1;
    step(1);
    chk("rst_sel", mux_sel, 1'b0);
    chk("rst_en", path_en, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", switch_done, 1'b0);
    step(20);
    chk("idle_sel", mux_sel, 1'b0);
    chk("idle_busy", busy, 1'b0);
    // full switch to test
    req_test = 1'b1;
    step(1);
    chk("e0_busy", busy, 1'b1);
    chk("e0_en", path_en, 1'b0);
    step(4);
    chk("e4_sel", mux_sel, 1'b0);
    step(1);
    chk("e5_sel", mux_sel, 1'b1);
    step(7);
    chk("e12_en", path_en, 1'b0);
    chk("e12_done", switch_done, 1'b0);
    step(1);
    chk("e13_en", path_en, 1'b1);
    chk("e13_done", switch_done, 1'b1);
    chk("e13_busy", busy, 1'b0);
    step(1);
    chk("e14_done", switch_done, 1'b0);
    req_test = 1'b0;
    step(16);
    chk("back_sel", mux_sel, 1'b0);
    // abort in quiesce
    req_test = 1'b1;
    step(2);
    req_test = 1'b0;
    step(1);
    chk("abort_busy", busy, 1'b0);
    chk("abort_en", path_en, 1'b1);
    chk("abort_sel", mux_sel, 1'b0);
    step(15);
    // lock hold-off, then lock asserted mid-settle
    lock = 1'b1;
    req_test = 1'b1;
    step(10);
    chk("lock_busy", busy, 1'b0);
    lock = 1'b0;
    step(1);
    chk("l_busy", busy, 1'b1);
    step(5);
    chk("l5_sel", mux_sel, 1'b1);
    step(2);
    lock = 1'b1;
    step(6);
    chk("l13_done", switch_done, 1'b1);
    req_test = 1'b0;
    step(5);
    chk("locked_hold", busy, 1'b0);
    lock = 1'b0;
    step(16);
    chk("unlock_sel", mux_sel, 1'b0);
    // reset mid-settle
    req_test = 1'b1;
    step(7);
    rst = 1'b0;
    step(1);
    chk("mrst_sel", mux_sel, 1'b0);
    chk("mrst_en", path_en, 1'b1);
    chk("mrst_busy", busy, 1'b0);
    rst = 1'b1;
    step(1);
    chk("restart_busy", busy, 1'b1);
    step(16);
    chk("restart_sel", mux_sel, 1'b1);
    req_test = 1'b0;
    step(16);
    // back-to-back
    req_test = 1'b1;
    step(7);
    req_test = 1'b0;
    step(7);
    chk("b2b_done1", switch_done, 1'b1);
    chk("b2b_sel1", mux_sel, 1'b1);
    step(1);
    chk("b2b_busy2", busy, 1'b1);
    step(5);
    chk("b2b_sel2", mux_sel, 1'b0);
    step(7);
    chk("b2b_e26_done", switch_done, 1'b0);
    step(1);
    chk("b2b_done2", switch_done, 1'b1);
    step(3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
